// File: rtl/led_ring_monitor.sv
// Checker for a one-hot rotating LED bus: verifies single left-rotates on strobed
// steps and held patterns otherwise, reports position, revolutions and first fault.
module led_ring_monitor #(
    parameter  int NB_LEDS  = 4,
    parameter  int NB_COUNT = 8,
    localparam int NB_POS   = $clog2(NB_LEDS)
) (
    input  logic                clock,
    input  logic                i_reset_n,
    input  logic [NB_LEDS-1:0]  i_led,
    input  logic                i_valid,
    input  logic                i_clear,
    output logic [NB_POS-1:0]   o_pos,
    output logic                o_locked,
    output logic                o_wrap,
    output logic [NB_COUNT-1:0] o_rev_count,
    output logic                o_err,
    output logic [1:0]          o_err_code
);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_TRACK,
        ST_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic [NB_LEDS-1:0]  prev_q, prev_d;
    logic                valid_q, valid_d;
    logic [NB_POS-1:0]   pos_q, pos_d;
    logic                wrap_q, wrap_d;
    logic [NB_COUNT-1:0] rev_q, rev_d;
    logic [1:0]          code_q, code_d;

    logic [NB_LEDS-1:0]  exp_led;
    logic                led_onehot;
    logic [NB_POS-1:0]   led_idx;

    // valid_q marks that the shifter advanced on the previous edge, so the
    // pattern seen now must be the rotated one.
    always_comb begin
        exp_led    = valid_q ? {prev_q[NB_LEDS-2:0], prev_q[NB_LEDS-1]} : prev_q;
        led_onehot = $onehot(i_led);
        led_idx    = '0;
        for (int unsigned i = 0; i < NB_LEDS; i++) begin
            if (i_led[i]) begin
                led_idx = NB_POS'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        valid_d = i_valid;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        rev_d   = rev_q;
        code_d  = code_q;
        if (i_clear) begin
            state_d = ST_SYNC;
            rev_d   = '0;
            code_d  = '0;
        end else begin
            unique case (state_q)
                ST_SYNC: begin
                    if (led_onehot) begin
                        prev_d  = i_led;
                        pos_d   = led_idx;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (i_led == exp_led) begin
                        prev_d = i_led;
                        pos_d  = led_idx;
                        if (valid_q && prev_q[NB_LEDS-1]) begin
                            wrap_d = 1'b1;
                            if (rev_q != '1) begin
                                rev_d = rev_q + NB_COUNT'(1);
                            end
                        end
                    end else if (!led_onehot) begin
                        state_d = ST_FAULT;
                        code_d  = 2'b01;
                    end else begin
                        state_d = ST_FAULT;
                        code_d  = 2'b10;
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_SYNC;
            prev_q  <= '0;
            valid_q <= 1'b0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            rev_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            rev_q   <= rev_d;
            code_q  <= code_d;
        end
    end

    assign o_pos       = pos_q;
    assign o_locked    = (state_q == ST_TRACK);
    assign o_wrap      = wrap_q;
    assign o_rev_count = rev_q;
    assign o_err       = (state_q == ST_FAULT);
    assign o_err_code  = code_q;

endmodule

// File: tb/tb_led_ring_monitor.sv
// Randomised bench for led_ring_monitor: a default instance and a 2-bit-counter
// instance share stimulus and are checked against a position-based ring model.
module tb_led_ring_monitor;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] led;
    logic       v;
    logic       clr;

    logic [1:0] pos_a, pos_b;
    logic       locked_a, locked_b, wrap_a, wrap_b, err_a, err_b;
    logic [7:0] rev_a;
    logic [1:0] rev_b;
    logic [1:0] code_a, code_b;

    led_ring_monitor #(.NB_LEDS(4), .NB_COUNT(8)) u_dut_a (
        .clock(clk), .i_reset_n(rst_n), .i_led(led), .i_valid(v), .i_clear(clr),
        .o_pos(pos_a), .o_locked(locked_a), .o_wrap(wrap_a), .o_rev_count(rev_a),
        .o_err(err_a), .o_err_code(code_a)
    );

    led_ring_monitor #(.NB_LEDS(4), .NB_COUNT(2)) u_dut_b (
        .clock(clk), .i_reset_n(rst_n), .i_led(led), .i_valid(v), .i_clear(clr),
        .o_pos(pos_b), .o_locked(locked_b), .o_wrap(wrap_b), .o_rev_count(rev_b),
        .o_err(err_b), .o_err_code(code_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: ring tracked as an integer position plus an unsaturated wrap total.
    bit m_locked, m_err, m_wrap, m_vd;
    int m_pos, m_rev, m_code;
    int wraps_b;
    int sh;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int x, input int lim);
        return (x > lim) ? lim : x;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_wrap = 0; m_vd = 0;
        m_pos = 0; m_rev = 0; m_code = 0;
    endtask

    task automatic model_edge(input logic [3:0] l, input bit vv, input bit cc);
        int nxt;
        m_wrap = 0;
        if (cc) begin
            m_locked = 0; m_err = 0; m_rev = 0; m_code = 0;
        end else if (m_err) begin
        end else if (!m_locked) begin
            if ($countones(l) == 1) begin
                m_pos = $clog2(l);
                m_locked = 1;
            end
        end else begin
            nxt = (m_pos + int'(m_vd)) % N;
            if (int'(l) == (1 << nxt)) begin
                m_wrap = m_vd && (m_pos == N - 1);
                if (m_wrap) m_rev++;
                m_pos = nxt;
            end else begin
                m_locked = 0;
                m_err = 1;
                m_code = ($countones(l) == 1) ? 2 : 1;
            end
        end
        m_vd = vv;
    endtask

    task automatic step(input logic [3:0] l, input bit vv, input bit cc);
        led = l; v = vv; clr = cc;
        @(posedge clk);
        model_edge(l, vv, cc);
        #1;
        if (wrap_b) wraps_b++;
        check("pos", 32'(pos_a), 32'(m_pos));
        check("locked", 32'(locked_a), 32'(m_locked));
        check("wrap", 32'(wrap_a), 32'(m_wrap));
        check("err", 32'(err_a), 32'(m_err));
        check("code", 32'(code_a), 32'(m_code));
        check("rev_a", 32'(rev_a), 32'(sat(m_rev, 255)));
        check("rev_b", 32'(rev_b), 32'(sat(m_rev, 3)));
        check("wrap_b", 32'(wrap_b), 32'(m_wrap));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pos"}, 32'(pos_a), 0);
        check({tag, "_locked"}, 32'(locked_a), 0);
        check({tag, "_wrap"}, 32'(wrap_a), 0);
        check({tag, "_rev"}, 32'(rev_a), 0);
        check({tag, "_err"}, 32'(err_a), 0);
        check({tag, "_code"}, 32'(code_a), 0);
        check({tag, "_rev_b"}, 32'(rev_b), 0);
    endtask

    // Called just after a checked edge: asserts reset between edges, releases before the next.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 check_zero("areset");
        model_reset();
        #4 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; led = '0; v = 1'b0; clr = 1'b0;
        model_reset();
        wraps_b = 0;
        #3 check_zero("reset");
        #5 rst_n = 1'b1;

        // Correct rotation with 8 strobes from 0001
        for (int k = 0; k < 8; k++) step(4'(1 << (k % 4)), 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        check("t1_rev", 32'(rev_a), 2);
        check("t1_locked", 32'(locked_a), 1);

        // Not one-hot while holding at 0100
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0110, 1'b0, 1'b0);
        check("t2_code", 32'(code_a), 1);
        check("t2_pos", 32'(pos_a), 2);

        // Strobed step from 0010 lands on 1000
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        check("t3_code", 32'(code_a), 2);
        step(4'b1000, 1'b0, 1'b1);
        check("t3_err_clr", 32'(err_a), 0);
        check("t3_unlocked", 32'(locked_a), 0);
        step(4'b0001, 1'b0, 1'b0);
        check("t3_relock", 32'(locked_a), 1);

        // Unstrobed movement
        step(4'b0010, 1'b0, 1'b0);
        check("t4_code", 32'(code_a), 2);

        // Five revolutions: narrow counter saturates, wrap keeps pulsing
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 1'b0);
        wraps_b = 0;
        for (int k = 0; k < 20; k++) step(4'(1 << (k % 4)), 1'b1, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        check("t5_rev_b", 32'(rev_b), 3);
        check("t5_rev_a", 32'(rev_a), 5);
        check("t5_wraps", 32'(wraps_b), 5);

        // Async reset mid-revolution, then relock
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        async_reset();
        step(4'b0100, 1'b0, 1'b0);
        check("t6_relock", 32'(locked_a), 1);

        // Randomised phase: shifter model with faults, clears, jumps and resets
        sh = 2;
        for (int c = 0; c < 600; c++) begin
            int r;
            logic [3:0] l;
            bit vv, cc;
            r  = $urandom_range(0, 99);
            vv = ($urandom_range(0, 1) == 1);
            cc = 1'b0;
            l  = 4'(1 << sh);
            if (r < 3) begin
                l = 4'($urandom);
            end else if (r < 8) begin
                cc = 1'b1;
            end else if (r < 9) begin
                sh = 0;
                l  = 4'b0001;
                cc = ($urandom_range(0, 1) == 1);
            end
            step(l, vv, cc);
            if (vv) sh = (sh + 1) % N;
            if (r == 99) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
